ym3438_mixer: RTL and testbench

YM3438_MIXER -- requirements
Module: ym3438_mixer

---
 rtl/ym3438_mixer.sv | 110 +++++++++++
 tb/tb_ym3438_mixer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ym3438_mixer.sv
// YM3438 output mixer: sums 24 offset-binary slot samples per frame into a stereo sample (x4, or x8 saturated with YM3438_MIX_GAIN8_EN).
// Latency 1 MCLK from the slot-23 strobe; held sample waits for out_ready, and a newer frame overwrites it and sets sticky overflow.
module ym3438_mixer (
  input  logic        MCLK,
  input  logic        IC,
  input  logic        fm_clk1,
  input  logic        sync,
  input  logic [8:0]  MOL,
  input  logic [8:0]  MOR,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        overflow,
  output logic [4:0]  slot
);

  logic        clk1_prev_q, clk1_prev_d;
  logic [4:0]  slot_q, slot_d;
  logic [13:0] acc_l_q, acc_l_d;
  logic [13:0] acc_r_q, acc_r_d;
  logic        frame_ok_q, frame_ok_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_l_q, out_l_d;
  logic [15:0] out_r_q, out_r_d;
  logic        overflow_q, overflow_d;

  logic        strobe;
  logic        frame_done;
  logic [4:0]  slot_next;
  logic [13:0] samp_l, samp_r;
  logic [13:0] sum_l, sum_r;

  function automatic logic [15:0] scale(input logic [13:0] s);
    logic [16:0] x8;
    x8 = {s, 3'b000};
`ifdef YM3438_MIX_GAIN8_EN
    if (x8[16] != x8[15]) begin
      scale = x8[16] ? 16'h8000 : 16'h7fff;
    end else begin
      scale = x8[15:0];
    end
`else
    scale = {s[13], s, 1'b0} ;
    scale = x8[16:1];
`endif
  endfunction

  always_comb begin
    strobe    = fm_clk1 & ~clk1_prev_q;
    slot_next = (sync || slot_q == 5'd23) ? 5'd0 : slot_q + 5'd1;

    // Offset binary to two's complement is an MSB flip.
    samp_l = {{5{~MOL[8]}}, ~MOL[8], MOL[7:0]};
    samp_r = {{5{~MOR[8]}}, ~MOR[8], MOR[7:0]};
    sum_l  = (slot_next == 5'd0) ? samp_l : acc_l_q + samp_l;
    sum_r  = (slot_next == 5'd0) ? samp_r : acc_r_q + samp_r;

    // A frame only counts if its slot 0 was seen since reset.
    frame_done = strobe && frame_ok_q && (slot_next == 5'd23);

    clk1_prev_d = fm_clk1;
    slot_d      = slot_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    frame_ok_d  = frame_ok_q;
    if (strobe) begin
      slot_d     = slot_next;
      acc_l_d    = sum_l;
      acc_r_d    = sum_r;
      frame_ok_d = frame_ok_q | (slot_next == 5'd0);
    end

    out_valid_d = frame_done | (out_valid_q & ~out_ready);
    overflow_d  = overflow_q | (frame_done & out_valid_q & ~out_ready);
    out_l_d     = frame_done ? scale(sum_l) : out_l_q;
    out_r_d     = frame_done ? scale(sum_r) : out_r_q;
  end

  always_ff @(posedge MCLK) begin
    if (!IC) begin
      clk1_prev_q <= 1'b1;
      slot_q      <= 5'd0;
      acc_l_q     <= 14'd0;
      acc_r_q     <= 14'd0;
      frame_ok_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_l_q     <= 16'd0;
      out_r_q     <= 16'd0;
      overflow_q  <= 1'b0;
    end else begin
      clk1_prev_q <= clk1_prev_d;
      slot_q      <= slot_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      frame_ok_q  <= frame_ok_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign overflow  = overflow_q;
  assign slot      = slot_q;

endmodule

// File: tb/tb_ym3438_mixer.sv
// Directed bench for ym3438_mixer: hand-computed frame sums, handshake, overflow, resync and reset cases.
module tb_ym3438_mixer;

  logic        MCLK = 1'b0;
  logic        IC;
  logic        fm_clk1;
  logic        sync;
  logic [8:0]  MOL;
  logic [8:0]  MOR;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        overflow;
  logic [4:0]  slot;

  int n_chk = 0;
  int n_err = 0;

`ifdef YM3438_MIX_GAIN8_EN
  localparam int EXP_MAX  = 32767;
  localparam int EXP_MIN  = -32768;
  localparam int EXP_ONE  = 8;
  localparam int EXP_24   = 192;
`else
  localparam int EXP_MAX  = 24480;
  localparam int EXP_MIN  = -24576;
  localparam int EXP_ONE  = 4;
  localparam int EXP_24   = 96;
`endif

  ym3438_mixer dut (
    .MCLK      (MCLK),
    .IC        (IC),
    .fm_clk1   (fm_clk1),
    .sync      (sync),
    .MOL       (MOL),
    .MOR       (MOR),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_l     (out_l),
    .out_r     (out_r),
    .overflow  (overflow),
    .slot      (slot)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One FM slot: fm_clk1 high for one MCLK (the strobe), then low for one.
  // Returns at the negedge just after the strobe edge.
  task automatic strobe(input bit s, input logic [8:0] l, input logic [8:0] r, input bit rdy);
    @(negedge MCLK);
    fm_clk1   = 1'b1;
    sync      = s;
    MOL       = l;
    MOR       = r;
    out_ready = rdy;
    @(negedge MCLK);
    fm_clk1   = 1'b0;
    sync      = 1'b0;
    MOL       = 9'h0aa;
    MOR       = 9'h155;
    out_ready = 1'b0;
  endtask

  task automatic frame(input logic [8:0] lb, input logic [8:0] rb, input int sp,
                       input logic [8:0] sl, input bit last_rdy);
    for (int i = 0; i < 24; i++) begin
      strobe(i == 0, (i == sp) ? sl : lb, rb, (i == 23) && last_rdy);
      if (slot != 5'(i)) check("slot_seq", int'(slot), i);
    end
  endtask

  task automatic accept();
    @(negedge MCLK);
    out_ready = 1'b1;
    @(negedge MCLK);
    out_ready = 1'b0;
    check("accept_valid", int'(out_valid), 0);
  endtask

  initial begin
    IC = 1'b0; fm_clk1 = 1'b0; sync = 1'b0;
    MOL = 9'h100; MOR = 9'h100; out_ready = 1'b0;
    repeat (3) @(negedge MCLK);
    check("rst_valid", int'(out_valid), 0);
    check("rst_l", int'(out_l), 0);
    check("rst_r", int'(out_r), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_slot", int'(slot), 0);
    IC = 1'b1;

    // Silence: all slots at zero.
    for (int i = 0; i < 23; i++) strobe(i == 0, 9'h100, 9'h100, 1'b0);
    check("zero_pre_valid", int'(out_valid), 0);
    check("zero_slot22", int'(slot), 22);
    strobe(1'b0, 9'h100, 9'h100, 1'b0);
    check("zero_valid", int'(out_valid), 1);
    check("zero_l", int'($signed(out_l)), 0);
    check("zero_r", int'($signed(out_r)), 0);
    check("zero_slot23", int'(slot), 23);
    accept();

    // Full-scale extremes.
    frame(9'h1ff, 9'h000, -1, 9'h100, 1'b0);
    check("max_valid", int'(out_valid), 1);
    check("max_l", int'($signed(out_l)), EXP_MAX);
    check("min_r", int'($signed(out_r)), EXP_MIN);

    // Single LSB in slot 5; previous sample still held and accepted on the update edge.
    frame(9'h100, 9'h100, 5, 9'h101, 1'b1);
    check("lsb_valid_wins", int'(out_valid), 1);
    check("lsb_l", int'($signed(out_l)), EXP_ONE);
    check("lsb_r", int'($signed(out_r)), 0);
    check("lsb_no_ovf", int'(overflow), 0);
    accept();

    // Two frames without ready: second overwrites, overflow sticks.
    frame(9'h1ff, 9'h000, -1, 9'h100, 1'b0);
    check("ovf_first", int'(overflow), 0);
    frame(9'h100, 9'h100, 5, 9'h101, 1'b0);
    check("ovf_set", int'(overflow), 1);
    check("ovf_l", int'($signed(out_l)), EXP_ONE);
    check("ovf_r", int'($signed(out_r)), 0);
    accept();
    check("ovf_sticky", int'(overflow), 1);

    // Resync at index 10: partial frame dropped.
    for (int i = 0; i < 10; i++) strobe(i == 0, 9'h1ff, 9'h000, 1'b0);
    strobe(1'b1, 9'h101, 9'h100, 1'b0);
    check("resync_slot", int'(slot), 0);
    check("resync_valid", int'(out_valid), 0);
    for (int i = 1; i < 23; i++) strobe(1'b0, 9'h101, 9'h100, 1'b0);
    check("resync_pre_valid", int'(out_valid), 0);
    strobe(1'b0, 9'h101, 9'h100, 1'b0);
    check("resync_valid_out", int'(out_valid), 1);
    check("resync_l", int'($signed(out_l)), EXP_24);
    check("resync_r", int'($signed(out_r)), 0);

    // Reset mid-frame at slot 12 with a sample still held.
    for (int i = 0; i <= 12; i++) strobe(i == 0, 9'h1ff, 9'h1ff, 1'b0);
    check("mid_slot", int'(slot), 12);
    IC = 1'b0;
    @(negedge MCLK);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_l", int'(out_l), 0);
    check("mid_rst_r", int'(out_r), 0);
    check("mid_rst_ovf", int'(overflow), 0);
    check("mid_rst_slot", int'(slot), 0);
    IC = 1'b1;
    // Without sync, the index runs 1..23 first: that partial frame must not output.
    for (int i = 1; i <= 23; i++) strobe(1'b0, 9'h1ff, 9'h1ff, 1'b0);
    check("post_rst_slot", int'(slot), 23);
    check("post_rst_valid", int'(out_valid), 0);
    frame(9'h100, 9'h000, 5, 9'h101, 1'b0);
    check("post_rst_out", int'(out_valid), 1);
    check("post_rst_l", int'($signed(out_l)), EXP_ONE);
    check("post_rst_r", int'($signed(out_r)), EXP_MIN);

    // fm_clk1 stuck low: everything holds.
    repeat (20) @(negedge MCLK);
    check("stuck_slot", int'(slot), 23);
    check("stuck_valid", int'(out_valid), 1);
    check("stuck_l", int'($signed(out_l)), EXP_ONE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
